// File: rtl/rx_pkg.sv
// Shared encodings and default thresholds for the NanEye Manchester receive path.
package rx_pkg;

  typedef enum logic [1:0] {
    HUNT = 2'b00,
    MID  = 2'b01,
    HALF = 2'b11
  } dec_state_e;

  typedef enum logic [1:0] {
    RUN_GLITCH = 2'd0,
    RUN_SHORT  = 2'd1,
    RUN_LONG   = 2'd2,
    RUN_IDLE   = 2'd3
  } run_class_e;

  localparam int RUN_CNT_WIDTH_DEF = 8;
  localparam int SHORT_MIN_DEF     = 2;
  localparam int SHORT_MAX_DEF     = 6;
  localparam int LONG_MAX_DEF      = 12;
  localparam bit POLARITY_DEF      = 1'b0;

endpackage

// File: rtl/rx_edge_sync.sv
// Two-flop synchronizer, registered sample and registered edge pulse for the raw line.
// Edge and level appear 3 clocks after the sampling edge; no backpressure.
module rx_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic lvl,
  output logic edge_pulse
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic smp_q, smp_d;
  logic edge_q, edge_d;

  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
    smp_d   = sync2_q;
    edge_d  = sync2_q ^ smp_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      smp_q   <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      smp_q   <= smp_d;
      edge_q  <= edge_d;
    end
  end

  // smp_q already holds the post-edge level in the cycle edge_q is high
  assign lvl        = smp_q;
  assign edge_pulse = edge_q;

endmodule

// File: rtl/rx_manchester_decoder.sv
// Manchester decoder: classifies run lengths between line edges and strobes recovered bits.
// Strobe 4 cycles after the mid-bit edge is sampled; no backpressure, DEC_RSYNC forces re-hunt.
module rx_manchester_decoder
  import rx_pkg::*;
#(
  parameter int C_RUN_CNT_WIDTH = RUN_CNT_WIDTH_DEF,
  parameter int C_SHORT_MIN     = SHORT_MIN_DEF,
  parameter int C_SHORT_MAX     = SHORT_MAX_DEF,
  parameter int C_LONG_MAX      = LONG_MAX_DEF,
  parameter bit C_POLARITY      = POLARITY_DEF
) (
  input  logic SCLOCK,
  input  logic RESET,
  input  logic DEC_INPUT,
  input  logic DEC_RSYNC,
  output logic DEC_OUTPUT,
  output logic DEC_OUTPUT_EN,
  output logic DEC_ERROR,
  output logic DEC_LOCKED
);

  localparam int CW = C_RUN_CNT_WIDTH;
  localparam int RW = C_RUN_CNT_WIDTH + 1;
  localparam logic [RW-1:0] SHORT_MIN_L  = RW'(C_SHORT_MIN);
  localparam logic [RW-1:0] SHORT_MAX_L  = RW'(C_SHORT_MAX);
  localparam logic [RW-1:0] LONG_MAX_L   = RW'(C_LONG_MAX);
  localparam logic [CW-1:0] LONG_MAX_CNT = CW'(C_LONG_MAX);
  localparam logic [CW-1:0] CNT_SAT      = {CW{1'b1}};

  logic lvl, edge_pulse;

  dec_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_q, out_d;
  logic          en_q, en_d;
  logic          err_q, err_d;
  logic          locked_q, locked_d;
  logic [RW-1:0] run_len;
  run_class_e    run_cls;

  rx_edge_sync u_edge_sync (
    .clk        (SCLOCK),
    .rst_n      (RESET),
    .din        (DEC_INPUT),
    .lvl        (lvl),
    .edge_pulse (edge_pulse)
  );

  // Run length includes the edge cycle itself, hence count + 1
  always_comb begin
    run_len = {1'b0, cnt_q} + RW'(1);
    if (run_len < SHORT_MIN_L)       run_cls = RUN_GLITCH;
    else if (run_len <= SHORT_MAX_L) run_cls = RUN_SHORT;
    else if (run_len <= LONG_MAX_L)  run_cls = RUN_LONG;
    else                             run_cls = RUN_IDLE;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CW'(1);
    out_d   = out_q;
    en_d    = 1'b0;
    err_d   = 1'b0;
    if (DEC_RSYNC) begin
      state_d = HUNT;
      cnt_d   = '0;
    end else if (edge_pulse) begin
      cnt_d = '0;
      case (state_q)
        HUNT: begin
          if (run_cls == RUN_LONG) begin
            en_d    = 1'b1;
            out_d   = lvl ^ C_POLARITY;
            state_d = MID;
          end
        end
        MID: begin
          case (run_cls)
            RUN_LONG: begin
              en_d  = 1'b1;
              out_d = lvl ^ C_POLARITY;
            end
            RUN_SHORT:  state_d = HALF;
            RUN_GLITCH: begin
              err_d   = 1'b1;
              state_d = HUNT;
            end
            default:    state_d = HUNT;
          endcase
        end
        HALF: begin
          case (run_cls)
            RUN_SHORT: begin
              en_d    = 1'b1;
              out_d   = lvl ^ C_POLARITY;
              state_d = MID;
            end
            RUN_IDLE: state_d = HUNT;
            default: begin
              err_d   = 1'b1;
              state_d = HUNT;
            end
          endcase
        end
        default: state_d = HUNT;
      endcase
    end else if (state_q != HUNT && cnt_q >= LONG_MAX_CNT) begin
      // Any edge from here on would end an idle run: a frame gap, not an error
      state_d = HUNT;
    end
    locked_d = (state_d != HUNT);
  end

  always_ff @(posedge SCLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= HUNT;
      cnt_q    <= '0;
      out_q    <= 1'b0;
      en_q     <= 1'b0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      en_q     <= en_d;
      err_q    <= err_d;
      locked_q <= locked_d;
    end
  end

  assign DEC_OUTPUT    = out_q;
  assign DEC_OUTPUT_EN = en_q;
  assign DEC_ERROR     = err_q;
  assign DEC_LOCKED    = locked_q;

endmodule

// File: tb/tb_rx_manchester_decoder.sv
// Bench for rx_manchester_decoder: waveform tables checked against a run-length reference model.
module tb_rx_manchester_decoder;

  localparam int NMAX = 700;

  logic SCLOCK;
  logic RESET;
  logic DEC_INPUT;
  logic DEC_RSYNC;
  logic out0, en0, err0, lock0;
  logic out1, en1, err1, lock1;

  rx_manchester_decoder dut (
    .SCLOCK(SCLOCK), .RESET(RESET), .DEC_INPUT(DEC_INPUT), .DEC_RSYNC(DEC_RSYNC),
    .DEC_OUTPUT(out0), .DEC_OUTPUT_EN(en0), .DEC_ERROR(err0), .DEC_LOCKED(lock0)
  );

  rx_manchester_decoder #(.C_POLARITY(1'b1)) dut_inv (
    .SCLOCK(SCLOCK), .RESET(RESET), .DEC_INPUT(DEC_INPUT), .DEC_RSYNC(DEC_RSYNC),
    .DEC_OUTPUT(out1), .DEC_OUTPUT_EN(en1), .DEC_ERROR(err1), .DEC_LOCKED(lock1)
  );

  initial SCLOCK = 1'b0;
  always #5 SCLOCK = ~SCLOCK;

  int n_tests = 0;
  int n_fail  = 0;

  logic wave [NMAX];
  logic rs   [NMAX];
  int   len;

  logic e_en [NMAX], e_err [NMAX], e_lock [NMAX], e_out0 [NMAX], e_out1 [NMAX];
  logic dut_lock [NMAX];
  int   strobe_lbl [$];
  logic strobe_val [$];
  logic strobe_val1 [$];
  int   err_lbl [$];

  task automatic clear_stim();
    len = 0;
  endtask

  task automatic add_level(input logic v, input int k);
    for (int i = 0; i < k; i++) begin
      if (len < NMAX) begin
        wave[len] = v;
        rs[len]   = 1'b0;
        len++;
      end
    end
  endtask

  // Polarity-0 coding: a 1 is low then high, so its mid-bit edge rises
  task automatic add_bit(input logic b, input int h);
    add_level(~b, h);
    add_level(b, h);
  endtask

  task automatic add_alt(input int nbits, input int h, input logic first);
    for (int i = 0; i < nbits; i++) add_bit(first ^ logic'(i % 2), h);
  endtask

  // Reference: line transitions reach the decision point 3 cycles after being sampled;
  // run length is the distance in cycles since the previous decision (edge or resync).
  task automatic build_model();
    int   st;
    int   r;
    int   run;
    int   t;
    logic o0, o1, tr, prev;
    st = 0; r = -1; o0 = 1'b0; o1 = 1'b0;
    for (int p = 0; p < len; p++) begin
      e_en[p] = 1'b0; e_err[p] = 1'b0;
      t  = p - 3;
      tr = 1'b0;
      if (t >= 0) begin
        prev = (t == 0) ? 1'b0 : wave[t-1];
        tr   = (wave[t] != prev);
      end
      if (rs[p]) begin
        st = 0; r = p;
      end else if (tr) begin
        run = p - r; r = p;
        if (run > 12) st = 0;
        else if (st == 0) begin
          if (run >= 7) begin e_en[p] = 1'b1; st = 1; end
        end else if (st == 1) begin
          if (run >= 7) e_en[p] = 1'b1;
          else if (run >= 2) st = 2;
          else begin e_err[p] = 1'b1; st = 0; end
        end else begin
          if (run >= 2 && run <= 6) begin e_en[p] = 1'b1; st = 1; end
          else begin e_err[p] = 1'b1; st = 0; end
        end
        if (e_en[p]) begin o0 = wave[t]; o1 = ~wave[t]; end
      end else if (st != 0 && (p - 1 - r) >= 12) begin
        st = 0;
      end
      e_lock[p] = (st != 0);
      e_out0[p] = o0;
      e_out1[p] = o1;
    end
  endtask

  task automatic run_scenario(input string name);
    logic [7:0] got, exp;
    strobe_lbl.delete(); strobe_val.delete(); strobe_val1.delete(); err_lbl.delete();
    build_model();
    RESET = 1'b0; DEC_INPUT = 1'b0; DEC_RSYNC = 1'b0;
    repeat (2) @(posedge SCLOCK);
    #1;
    RESET = 1'b1; DEC_INPUT = wave[0]; DEC_RSYNC = rs[0];
    for (int p = 0; p < len; p++) begin
      @(posedge SCLOCK);
      #1;
      got = {en0, err0, lock0, out0, en1, err1, lock1, out1};
      exp = {e_en[p], e_err[p], e_lock[p], e_out0[p], e_en[p], e_err[p], e_lock[p], e_out1[p]};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL %s cycle=%0d {en,err,lock,out,en_i,err_i,lock_i,out_i} got=%b exp=%b",
                 name, p, got, exp);
      end
      dut_lock[p] = lock0;
      if (en0) begin strobe_lbl.push_back(p); strobe_val.push_back(out0); end
      if (en1) strobe_val1.push_back(out1);
      if (err0) err_lbl.push_back(p);
      if (p + 1 < len) begin DEC_INPUT = wave[p+1]; DEC_RSYNC = rs[p+1]; end
    end
  endtask

  task automatic test_reset();
    RESET = 1'b0; DEC_INPUT = 1'b0; DEC_RSYNC = 1'b0;
    #3;
    n_tests++;
    if ({out0, en0, err0, lock0, out1, en1, err1, lock1} !== 8'b0) begin
      n_fail++;
      $display("FAIL reset_init outputs got=%b exp=00000000",
               {out0, en0, err0, lock0, out1, en1, err1, lock1});
    end
    clear_stim(); add_level(1'b0, 20); add_alt(11, 4, 1'b1); add_level(wave[len-1], 3);
    run_scenario("pre_reset");
    RESET = 1'b0;
    #2;
    n_tests++;
    if ({out0, en0, err0, lock0, out1, en1, err1, lock1} !== 8'b0) begin
      n_fail++;
      $display("FAIL reset_midstream outputs got=%b exp=00000000",
               {out0, en0, err0, lock0, out1, en1, err1, lock1});
    end
  endtask

  task automatic test_alternating();
    clear_stim(); add_level(1'b0, 20); add_alt(12, 4, 1'b1); add_level(wave[len-1], 8);
    run_scenario("alt");
    n_tests++;
    if (strobe_lbl.size() != 11) begin
      n_fail++; $display("FAIL alt_count got=%0d exp=11", strobe_lbl.size());
    end
    n_tests++;
    if (strobe_lbl.size() == 0 || strobe_lbl[0] != 35) begin
      n_fail++;
      $display("FAIL alt_latency got=%0d exp=35", (strobe_lbl.size() == 0) ? -1 : strobe_lbl[0]);
    end
    for (int i = 1; i < strobe_lbl.size() && i < strobe_val1.size(); i++) begin
      n_tests++;
      if (strobe_lbl[i] - strobe_lbl[i-1] != 8 || strobe_val[i] !== logic'(i % 2)
          || strobe_val1[i] !== logic'(1 - (i % 2))) begin
        n_fail++;
        $display("FAIL alt_strobe%0d gap=%0d val=%b inv=%b exp gap=8 val=%b inv=%b", i,
                 strobe_lbl[i] - strobe_lbl[i-1], strobe_val[i], strobe_val1[i],
                 logic'(i % 2), logic'(1 - (i % 2)));
      end
    end
    n_tests++;
    if (err_lbl.size() != 0 || dut_lock[len-1] !== 1'b1) begin
      n_fail++;
      $display("FAIL alt_err_lock errors=%0d lock=%b exp errors=0 lock=1", err_lbl.size(), dut_lock[len-1]);
    end
  endtask

  task automatic test_constant();
    int idx_zero;
    clear_stim(); add_level(1'b0, 20);
    for (int i = 0; i < 10; i++) add_bit(1'b1, 4);
    idx_zero = len;
    add_bit(1'b0, 4);
    for (int i = 0; i < 8; i++) add_bit(1'b1, 4);
    add_level(wave[len-1], 8);
    run_scenario("const");
    n_tests++;
    if (strobe_lbl.size() != 9 || dut_lock[idx_zero-1] !== 1'b0) begin
      n_fail++;
      $display("FAIL const_count strobes=%0d lock_before=%b exp strobes=9 lock_before=0",
               strobe_lbl.size(), dut_lock[idx_zero-1]);
    end
    n_tests++;
    if (strobe_lbl.size() == 0 || strobe_lbl[0] != idx_zero + 7 || strobe_val[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL const_first got_lbl=%0d exp_lbl=%0d", (strobe_lbl.size() == 0) ? -1 : strobe_lbl[0],
               idx_zero + 7);
    end
    for (int i = 1; i < strobe_val.size(); i++) begin
      n_tests++;
      if (strobe_val[i] !== 1'b1) begin
        n_fail++; $display("FAIL const_val%0d got=%b exp=1", i, strobe_val[i]);
      end
    end
  endtask

  task automatic test_glitch();
    clear_stim(); add_level(1'b0, 20); add_alt(12, 4, 1'b1); add_level(wave[len-1], 8);
    wave[20 + 6*8 + 1] = ~wave[20 + 6*8 + 1];
    run_scenario("glitch");
    n_tests++;
    if (err_lbl.size() != 1 || strobe_lbl.size() != 10) begin
      n_fail++;
      $display("FAIL glitch_counts errors=%0d strobes=%0d exp errors=1 strobes=10",
               err_lbl.size(), strobe_lbl.size());
    end
    n_tests++;
    if (err_lbl.size() == 0 || dut_lock[err_lbl[0]] !== 1'b0 || dut_lock[len-1] !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_lock at_err=%b end=%b exp at_err=0 end=1",
               (err_lbl.size() == 0) ? 1'bx : dut_lock[err_lbl[0]], dut_lock[len-1]);
    end
  endtask

  task automatic test_idle();
    int t_last;
    clear_stim(); add_level(1'b0, 20); add_alt(8, 4, 1'b1);
    t_last = len - 4;
    add_level(1'b0, 20);
    add_alt(8, 4, 1'b1); add_level(wave[len-1], 8);
    run_scenario("idle");
    n_tests++;
    if (dut_lock[t_last + 11] !== 1'b1 || dut_lock[t_last + 20] !== 1'b0 || dut_lock[len-1] !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_lock before=%b gap=%b end=%b exp 1 0 1",
               dut_lock[t_last + 11], dut_lock[t_last + 20], dut_lock[len-1]);
    end
    n_tests++;
    if (err_lbl.size() != 0 || strobe_lbl.size() != 14) begin
      n_fail++;
      $display("FAIL idle_counts errors=%0d strobes=%0d exp errors=0 strobes=14",
               err_lbl.size(), strobe_lbl.size());
    end
  endtask

  task automatic test_rsync();
    int t;
    logic hit;
    clear_stim(); add_level(1'b0, 20); add_alt(12, 4, 1'b1); add_level(wave[len-1], 8);
    t = 20 + 6*8 + 4;
    for (int k = 2; k <= 4; k++) rs[t + k] = 1'b1;
    run_scenario("rsync");
    hit = 1'b0;
    foreach (strobe_lbl[i]) if (strobe_lbl[i] == t + 3) hit = 1'b1;
    n_tests++;
    if (hit || dut_lock[t + 4] !== 1'b0) begin
      n_fail++; $display("FAIL rsync_discard strobe=%b lock=%b exp strobe=0 lock=0", hit, dut_lock[t + 4]);
    end
    n_tests++;
    if (strobe_lbl.size() != 10 || err_lbl.size() != 0 || dut_lock[len-1] !== 1'b1) begin
      n_fail++;
      $display("FAIL rsync_resume strobes=%0d errors=%0d lock=%b exp 10 0 1",
               strobe_lbl.size(), err_lbl.size(), dut_lock[len-1]);
    end
  endtask

  task automatic test_random();
    int   h, pos, nrs;
    logic b;
    for (int it = 0; it < 5; it++) begin
      h = int'($urandom_range(4, 5));
      clear_stim(); add_level(1'b0, 20);
      for (int i = 0; i < 28; i++) begin
        b = 1'($urandom_range(0, 1));
        add_bit(b, h);
        if (i == 14 && $urandom_range(0, 1) == 1) add_level(b, int'($urandom_range(6, 20)));
      end
      add_level(wave[len-1], 8);
      if ($urandom_range(0, 1) == 1) begin
        pos = int'($urandom_range(40, len - 20));
        wave[pos] = ~wave[pos];
      end
      if ($urandom_range(0, 1) == 1) begin
        pos = int'($urandom_range(40, len - 20));
        nrs = int'($urandom_range(1, 3));
        for (int k = 0; k < nrs; k++) rs[pos + k] = 1'b1;
      end
      run_scenario("random");
    end
  endtask

  initial begin
    test_reset();
    test_alternating();
    test_constant();
    test_glitch();
    test_idle();
    test_rsync();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
